// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module : mul_pkg
// Brief  : Shared types for the iterative radix-4 Booth multiplier.
// Rev    : 1.0  initial release
// ============================================================================
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      POS1 = 3'd1,
      POS2 = 3'd2,
      NEG1 = 3'd3,
      NEG2 = 3'd4
   } booth_sel_t;

   // Bit positions inside mul_signed
   localparam int c_MCAND_SGN = 1;
   localparam int c_MPLR_SGN  = 0;

   function automatic booth_sel_t booth_decode(input logic [2:0] win);
      booth_sel_t sel;
      case (win)
         3'b001, 3'b010: sel = POS1;
         3'b011:         sel = POS2;
         3'b100:         sel = NEG2;
         3'b101, 3'b110: sel = NEG1;
         default:        sel = ZERO;
      endcase
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/booth_pp_sel.sv
`default_nettype none
// ============================================================================
// Module : booth_pp_sel
// Brief  : Radix-4 Booth partial-product select; negation is one's complement
//          here, the +1 is supplied as carry-in by the accumulator adder.
// Rev    : 1.0  initial release
// ============================================================================
module booth_pp_sel
   import mul_pkg::*;
#(
   parameter int W = 64
) (
   input  logic [2:0]   window,
   input  logic [W+1:0] x_ext,
   output logic [W+2:0] pp,
   output logic         neg
);

   booth_sel_t   w_sel;
   logic [W+2:0] w_mag;

   always_comb begin
      w_sel = booth_decode(window);
      w_mag = '0;
      case (w_sel)
         POS1, NEG1: w_mag = {x_ext[W+1], x_ext};
         POS2, NEG2: w_mag = {x_ext, 1'b0};
         default:    w_mag = '0;
      endcase
      neg = (w_sel == NEG1) || (w_sel == NEG2);
      pp  = neg ? ~w_mag : w_mag;
   end

endmodule
`default_nettype wire

// File: rtl/iter_booth_mul.sv
`default_nettype none
// ============================================================================
// Module : iter_booth_mul
// Brief  : Iterative radix-4 Booth multiplier, 2 multiplier bits per cycle,
//          with valid/ready handshakes, flush and a half-width word mode.
// Rev    : 1.0  initial release
// ============================================================================
module iter_booth_mul
   import mul_pkg::*;
#(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         flush,
   input  logic [1:0]   mul_signed,
   input  logic         word_op,
   input  logic [W-1:0] multiplicand,
   input  logic [W-1:0] multiplier,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result_hi,
   output logic [W-1:0] result_lo
);

   localparam int N_FULL  = (W + 2) / 2;
   localparam int N_WORD  = (W / 2 + 2) / 2;
   localparam int c_HW    = W / 2;
   localparam int c_ACC_W = 2 * W + 4;
   localparam int c_CNT_W = $clog2(N_FULL + 1);

   state_t             r_state;
   logic [c_CNT_W-1:0] r_count;
   logic [c_CNT_W-1:0] r_idx;
   logic [W+1:0]       r_mcand;
   logic [W+1:0]       r_mplr;
   logic               r_prev;
   logic               r_word;
   logic [c_ACC_W-1:0] r_acc;

   logic               w_a_sx;
   logic               w_b_sx;
   logic [W+1:0]       w_a_ext;
   logic [W+1:0]       w_b_ext;
   logic [W+2:0]       w_pp;
   logic               w_neg;
   logic [c_ACC_W-1:0] w_pp_ext;
   logic [c_CNT_W:0]   w_shamt;
   logic [c_ACC_W-1:0] w_acc_next;

   // Word ops extend from bit W/2-1 so the upper operand halves are ignored
   assign w_a_sx  = mul_signed[c_MCAND_SGN] & (word_op ? multiplicand[c_HW-1] : multiplicand[W-1]);
   assign w_b_sx  = mul_signed[c_MPLR_SGN]  & (word_op ? multiplier[c_HW-1]   : multiplier[W-1]);
   assign w_a_ext = word_op ? {{(W+2-c_HW){w_a_sx}}, multiplicand[c_HW-1:0]}
                            : {{2{w_a_sx}}, multiplicand};
   assign w_b_ext = word_op ? {{(W+2-c_HW){w_b_sx}}, multiplier[c_HW-1:0]}
                            : {{2{w_b_sx}}, multiplier};

   booth_pp_sel #(.W(W)) u_pp_sel (
      .window (({r_mplr[1:0], r_prev})),
      .x_ext  (r_mcand),
      .pp     (w_pp),
      .neg    (w_neg)
   );

   assign w_pp_ext   = {{(c_ACC_W-(W+3)){w_pp[W+2]}}, w_pp};
   assign w_shamt    = {r_idx, 1'b0};
   assign w_acc_next = r_acc + (w_pp_ext << w_shamt) + (c_ACC_W'(w_neg) << w_shamt);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_count   <= '0;
         r_idx     <= '0;
         r_mcand   <= '0;
         r_mplr    <= '0;
         r_prev    <= 1'b0;
         r_word    <= 1'b0;
         r_acc     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result_hi <= '0;
         result_lo <= '0;
      end else if (flush) begin
         r_state   <= IDLE;
         r_count   <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_mcand  <= w_a_ext;
                  r_mplr   <= w_b_ext;
                  r_prev   <= 1'b0;
                  r_word   <= word_op;
                  r_acc    <= '0;
                  r_idx    <= '0;
                  r_count  <= word_op ? c_CNT_W'(N_WORD) : c_CNT_W'(N_FULL);
                  in_ready <= 1'b0;
                  r_state  <= BUSY;
               end
            end
            BUSY: begin
               r_acc   <= w_acc_next;
               r_prev  <= r_mplr[1];
               r_mplr  <= {2'b00, r_mplr[W+1:2]};
               r_idx   <= r_idx + 1'b1;
               r_count <= r_count - 1'b1;
               if (r_count == c_CNT_W'(1)) begin
                  r_state   <= DONE;
                  out_valid <= 1'b1;
                  if (r_word) begin
                     result_hi <= '0;
                     result_lo <= {{(W-c_HW){w_acc_next[c_HW-1]}}, w_acc_next[c_HW-1:0]};
                  end else begin
                     result_hi <= w_acc_next[2*W-1:W];
                     result_lo <= w_acc_next[W-1:0];
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state   <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state   <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_iter_booth_mul.sv
`default_nettype none
// ============================================================================
// Module : tb_iter_booth_mul
// Brief  : Self-checking bench for iter_booth_mul against a cycle-count
//          behavioural model using plain wide-integer multiplication.
// Rev    : 1.0  initial release
// ============================================================================
module tb_iter_booth_mul;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic          flush;
   logic [1:0]    mul_signed;
   logic          word_op;
   logic [W-1:0]  multiplicand;
   logic [W-1:0]  multiplier;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result_hi;
   logic [W-1:0]  result_lo;

   int n_tests = 0;
   int n_fail  = 0;
   logic rand_ready = 1'b0;

   // Model: phase 0 idle, 1 computing, 2 result pending
   int           m_phase = 0;
   int           m_left  = 0;
   logic [127:0] m_pend  = '0;
   logic [127:0] m_res   = '0;
   logic         m_ready = 1'b1;
   logic         m_valid = 1'b0;

   always #5 clk = ~clk;

   iter_booth_mul #(.W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .flush        (flush),
      .mul_signed   (mul_signed),
      .word_op      (word_op),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result_hi    (result_hi),
      .result_lo    (result_lo)
   );

   function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] sg, input logic wd);
      logic signed [129:0] ea;
      logic signed [129:0] eb;
      logic signed [259:0] p;
      if (wd) begin
         ea = {{98{sg[1] & a[31]}}, a[31:0]};
         eb = {{98{sg[0] & b[31]}}, b[31:0]};
      end else begin
         ea = {{66{sg[1] & a[63]}}, a};
         eb = {{66{sg[0] & b[63]}}, b};
      end
      p = ea * eb;
      if (wd) return {64'd0, {32{p[31]}}, p[31:0]};
      return p[127:0];
   endfunction

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 5))
         0:       return 64'd0;
         1:       return '1;
         2:       return 64'h8000_0000_0000_0000;
         3:       return 64'd1;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; m_ready = 1'b1; m_valid = 1'b0; m_res = '0;
      end else if (flush) begin
         m_phase = 0; m_ready = 1'b1; m_valid = 1'b0;
      end else if (m_phase == 0) begin
         if (in_valid) begin
            m_pend  = ref_mul(multiplicand, multiplier, mul_signed, word_op);
            m_left  = word_op ? 17 : 33;
            m_phase = 1;
            m_ready = 1'b0;
         end
      end else if (m_phase == 1) begin
         m_left--;
         if (m_left == 0) begin
            m_phase = 2; m_valid = 1'b1; m_res = m_pend;
         end
      end else if (out_ready) begin
         m_phase = 0; m_valid = 1'b0; m_ready = 1'b1;
      end
   end

   always @(posedge clk) begin
      #1;
      check("in_ready", 128'(in_ready), 128'(m_ready));
      check("out_valid", 128'(out_valid), 128'(m_valid));
      if (m_valid) check("result", {result_hi, result_lo}, m_res);
   end

   always @(negedge clk) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sg,
                         input logic wd, input int lat, input logic [127:0] exp, input int hold);
      int t;
      int cyc;
      logic [127:0] held;
      @(negedge clk);
      t = 0;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("accept_wait", 128'(in_ready), 128'd1);
      multiplicand = a; multiplier = b; mul_signed = sg; word_op = wd; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      multiplicand = {$urandom, $urandom}; multiplier = {$urandom, $urandom};
      mul_signed = 2'($urandom); word_op = ~wd;
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         @(posedge clk);
         cyc++;
         #1;
      end
      check("latency", 128'(cyc), 128'(lat));
      check("product", {result_hi, result_lo}, exp);
      held = {result_hi, result_lo};
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check("hold_valid", 128'(out_valid), 128'd1);
         check("hold_ready", 128'(in_ready), 128'd0);
         check("hold_result", {result_hi, result_lo}, held);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("release_valid", 128'(out_valid), 128'd0);
      check("release_ready", 128'(in_ready), 128'd1);
   endtask

   initial begin
      int seen;
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      mul_signed = 2'b00; word_op = 1'b0; multiplicand = '0; multiplier = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ready", 128'(in_ready), 128'd1);
      check("reset_valid", 128'(out_valid), 128'd0);
      check("reset_result", {result_hi, result_lo}, 128'd0);
      rst = 1'b0;

      check("pin_ss", ref_mul('1, '1, 2'b11, 1'b0), {64'd0, 64'd1});
      check("pin_uu", ref_mul('1, '1, 2'b00, 1'b0), {64'hFFFF_FFFF_FFFF_FFFE, 64'd1});
      check("pin_su", ref_mul('1, '1, 2'b10, 1'b0), {64'hFFFF_FFFF_FFFF_FFFF, 64'd1});
      check("pin_min", ref_mul(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b11, 1'b0),
            {64'h4000_0000_0000_0000, 64'd0});
      check("pin_word", ref_mul(64'h7FFF_FFFF, 64'd2, 2'b11, 1'b1), {64'd0, 64'hFFFF_FFFF_FFFF_FFFE});

      run_op('1, '1, 2'b11, 1'b0, 33, {64'd0, 64'd1}, 0);
      run_op('1, '1, 2'b00, 1'b0, 33, {64'hFFFF_FFFF_FFFF_FFFE, 64'd1}, 0);
      run_op('1, '1, 2'b10, 1'b0, 33, {64'hFFFF_FFFF_FFFF_FFFF, 64'd1}, 0);
      run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b11, 1'b0, 33,
             {64'h4000_0000_0000_0000, 64'd0}, 0);
      run_op(64'h7FFF_FFFF, 64'd2, 2'b11, 1'b1, 17, {64'd0, 64'hFFFF_FFFF_FFFF_FFFE}, 0);

      // Flush in the middle of a computation
      @(negedge clk);
      multiplicand = 64'd1234; multiplier = 64'd5678; mul_signed = 2'b00; word_op = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_ready", 128'(in_ready), 128'd1);
      check("flush_valid", 128'(out_valid), 128'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      check("flush_no_result", 128'(seen), 128'd0);
      run_op(64'd3, 64'd5, 2'b00, 1'b0, 33, {64'd0, 64'd15}, 0);

      // Back-pressure
      run_op(64'hDEAD_BEEF_0123_4567, 64'hFEDC_BA98_7654_3210, 2'b11, 1'b0, 33,
             ref_mul(64'hDEAD_BEEF_0123_4567, 64'hFEDC_BA98_7654_3210, 2'b11, 1'b0), 20);

      // Randomised traffic with random back-pressure, flushes and one reset
      rand_ready = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         in_valid     = ($urandom_range(0, 3) != 0);
         multiplicand = pick();
         multiplier   = pick();
         mul_signed   = 2'($urandom);
         word_op      = ($urandom_range(0, 2) == 0);
         flush        = ($urandom_range(0, 59) == 0);
         rst          = (c == 2000);
      end
      @(negedge clk);
      rand_ready = 1'b0; in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
